// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_reorder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

    // Reverses the low 'width' bits of 'value'; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < width) begin
                result[5'(width - 1 - b)] = value[5'(b)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// Contents are deliberately not reset.
module reorder_ram #(
    parameter int addr_width = 7,
    parameter int word_width = 32
) (
    input  logic                  clock,
    input  logic                  wrEn_i,
    input  logic [addr_width-1:0] wrAddr_i,
    input  logic [word_width-1:0] wrData_i,
    input  logic                  rdEn_i,
    input  logic [addr_width-1:0] rdAddr_i,
    output logic [word_width-1:0] rdData_o
);

    logic [word_width-1:0] mem_q [2**addr_width];

    // Write port: store the incoming sample at its bit-reversed slot.
    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Read port: one-cycle registered read.
    always_ff @(posedge clock) begin
        if (rdEn_i) begin
            rdData_o <= mem_q[rdAddr_i];
        end
    end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: takes the bit-reversed FFT output stream and
// re-emits each frame in natural bin order, one bank filling while the other drains.
module fft_reorder_buffer
    import fft_reorder_pkg::*;
#(
    parameter int data_width = 16,
    parameter int log2_n     = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [data_width-1:0] in_r,
    input  logic [data_width-1:0] in_i,
    output logic                  out_valid,
    output logic [data_width-1:0] out_r,
    output logic [data_width-1:0] out_i,
    output logic [log2_n-1:0]     out_index,
    output logic                  out_last,
    output logic                  sync_err
);

    localparam int ADDR_W = log2_n + 1;
    localparam int WORD_W = 2 * data_width;

    logic [log2_n-1:0] wrCnt_q;
    logic              wrBank_q;
    logic [log2_n-1:0] wrIdx;
    logic [log2_n-1:0] wrRev;
    logic              wrLast;
    logic              wrBad;

    logic [1:0]        full_q;
    logic [1:0]        full_d;

    rd_state_e         rdState_q;
    logic [log2_n-1:0] rdCnt_q;
    logic              rdBank_q;
    logic              rdIssue;
    logic              rdDone;
    logic [log2_n-1:0] rdIdx;

    logic              rdValid_q;
    logic [log2_n-1:0] rdIndex_q;
    logic [WORD_W-1:0] ramData;

    // Write-side decode: frame_start forces the sample to slot 0 and flags a resync if mid-frame.
    always_comb begin
        wrIdx  = frame_start ? '0 : wrCnt_q;
        wrRev  = log2_n'(bitrev(32'(wrIdx), log2_n));
        wrLast = enable && (wrIdx == '1);
        wrBad  = enable && frame_start && (wrCnt_q != '0);
    end

    // Write counter, write bank and the sticky resync flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrCnt_q  <= '0;
            wrBank_q <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (enable) begin
                wrCnt_q <= wrIdx + 1'b1;
            end
            if (wrLast) begin
                wrBank_q <= ~wrBank_q;
            end
            if (wrBad) begin
                sync_err <= 1'b1;
            end
        end
    end

    // Read issue: IDLE launches bin 0 the moment a bank is full, READ walks the rest.
    always_comb begin
        rdIssue = 1'b0;
        rdDone  = 1'b0;
        rdIdx   = rdCnt_q;
        case (rdState_q)
            ST_IDLE: begin
                rdIssue = full_q[rdBank_q];
                rdIdx   = '0;
            end
            ST_READ: begin
                rdIssue = 1'b1;
                rdDone  = (rdCnt_q == '1);
            end
            default: ;
        endcase
    end

    // Bank-full bits: cleared when a bank finishes draining, set (with priority) when it finishes filling.
    always_comb begin
        full_d = full_q;
        if (rdDone) begin
            full_d[rdBank_q] = 1'b0;
        end
        if (wrLast) begin
            full_d[wrBank_q] = 1'b1;
        end
    end

    // Bank-full register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Read FSM: bin 0 is issued from IDLE, so READ starts counting at 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdState_q <= ST_IDLE;
            rdCnt_q   <= '0;
            rdBank_q  <= 1'b0;
        end else begin
            case (rdState_q)
                ST_IDLE: begin
                    if (full_q[rdBank_q]) begin
                        rdState_q <= ST_READ;
                        rdCnt_q   <= log2_n'(1);
                    end
                end
                ST_READ: begin
                    if (rdCnt_q == '1) begin
                        rdCnt_q   <= '0;
                        rdBank_q  <= ~rdBank_q;
                        rdState_q <= full_q[~rdBank_q] ? ST_READ : ST_IDLE;
                    end else begin
                        rdCnt_q <= rdCnt_q + 1'b1;
                    end
                end
                default: rdState_q <= ST_IDLE;
            endcase
        end
    end

    reorder_ram #(
        .addr_width(ADDR_W),
        .word_width(WORD_W)
    ) u_ram (
        .clock   (clock),
        .wrEn_i  (enable),
        .wrAddr_i({wrBank_q, wrRev}),
        .wrData_i({in_r, in_i}),
        .rdEn_i  (rdIssue),
        .rdAddr_i({rdBank_q, rdIdx}),
        .rdData_o(ramData)
    );

    // Tracks which bin the RAM read data belongs to, aligned with the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdValid_q <= 1'b0;
            rdIndex_q <= '0;
        end else begin
            rdValid_q <= rdIssue;
            rdIndex_q <= rdIdx;
        end
    end

    // Output register stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_r     <= '0;
            out_i     <= '0;
        end else begin
            out_valid <= rdValid_q;
            out_last  <= rdValid_q && (rdIndex_q == '1);
            out_index <= rdIndex_q;
            if (rdValid_q) begin
                out_r <= ramData[WORD_W-1:data_width];
                out_i <= ramData[data_width-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Scoreboard bench for fft_reorder_buffer with N = 16.
module tb_fft_reorder_buffer;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int N  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          frame_start;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic          out_valid;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic [LN-1:0] out_index;
    logic          out_last;
    logic          sync_err;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        int          idx;
        int          cyc;
    } exp_t;

    exp_t        sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] frameR[N];
    logic [15:0] frameI[N];

    fft_reorder_buffer #(
        .data_width(DW),
        .log2_n    (LN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .frame_start(frame_start),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_index  (out_index),
        .out_last   (out_last),
        .sync_err   (sync_err)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Counts rising edges so expectations can name the exact output cycle.
    always @(posedge clock) cyc <= cyc + 1;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, required completion before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int bitrev4(input int k);
        logic [3:0] v;
        v = 4'(k);
        return int'({v[0], v[1], v[2], v[3]});
    endfunction

    task automatic compareVal(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d (0x%0h), required %0d (0x%0h), cycle %0d",
                     name, actual, actual, required, required, cyc);
        end
    endtask

    // Pops the next expected bin and compares every output field against it.
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: actual out_valid=1 index %0d at cycle %0d, required out_valid=0",
                     out_index, cyc);
        end else begin
            e = sbQ.pop_front();
            compareVal("out_cycle", cyc, e.cyc);
            compareVal("out_r", int'(out_r), int'(e.r));
            compareVal("out_i", int'(out_i), int'(e.i));
            compareVal("out_index", int'(out_index), e.idx);
            compareVal("out_last", int'(out_last), (e.idx == N - 1) ? 1 : 0);
        end
    endtask

    // Monitor: every valid output cycle is matched against the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b0 && out_valid === 1'b1) begin
            checkOutput();
        end
    end

    task automatic checkResetState();
        compareVal("reset_out_valid", int'(out_valid), 0);
        compareVal("reset_out_r", int'(out_r), 0);
        compareVal("reset_out_i", int'(out_i), 0);
        compareVal("reset_out_index", int'(out_index), 0);
        compareVal("reset_out_last", int'(out_last), 0);
        compareVal("reset_sync_err", int'(sync_err), 0);
    endtask

    task automatic loadRamp(input int rBase, input int iBase);
        for (int b = 0; b < N; b++) begin
            frameR[b] = 16'(rBase + b);
            frameI[b] = 16'(iBase + b);
        end
    endtask

    // Drives one frame in bit-reversed order; expected bins are queued once the last sample goes in.
    task automatic applyStimulus(input int gap, input int expSync0, input int expSync1);
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            if (k == 0) compareVal("sync_err_before_frame", int'(sync_err), expSync0);
            if (k == 1) compareVal("sync_err_after_start", int'(sync_err), expSync1);
            enable      = 1'b1;
            frame_start = (k == 0);
            in_r        = frameR[bitrev4(k)];
            in_i        = frameI[bitrev4(k)];
            if (k == N - 1) begin
                for (int b = 0; b < N; b++) begin
                    exp_t e;
                    e.r   = frameR[b];
                    e.i   = frameI[b];
                    e.idx = b;
                    e.cyc = cyc + 3 + b;
                    sbQ.push_back(e);
                end
            end else begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clock);
                    enable      = 1'b0;
                    frame_start = 1'b0;
                end
            end
        end
    endtask

    // Drives the head of a frame that never completes; nothing is expected from it.
    task automatic applyPartial(input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge clock);
            enable      = 1'b1;
            frame_start = (k == 0);
            in_r        = 16'hDEAD;
            in_i        = 16'(k);
        end
    endtask

    task automatic goIdle();
        @(negedge clock);
        enable      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        compareVal("drain_complete", sbQ.size(), 0);
        sbQ.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        in_r        = '0;
        in_i        = '0;
        repeat (3) @(negedge clock);
        checkResetState();
        reset = 1'b0;

        $display("[TB] single frame");
        loadRamp(0, 100);
        applyStimulus(0, 0, 0);
        goIdle();
        waitDrain();

        $display("[TB] four back-to-back frames");
        for (int f = 0; f < 4; f++) begin
            loadRamp(16 * (f + 1), 16'h4000 + 16 * f);
            applyStimulus(0, 0, 0);
        end
        goIdle();
        waitDrain();

        $display("[TB] gapped input, one sample every third cycle");
        loadRamp(0, 100);
        applyStimulus(2, 0, 0);
        goIdle();
        waitDrain();

        $display("[TB] mid-frame resync");
        loadRamp(16'h0100, 16'h0500);
        applyStimulus(0, 0, 0);
        applyPartial(7);
        loadRamp(16'h0200, 16'h0600);
        applyStimulus(0, 0, 1);
        goIdle();
        waitDrain();

        $display("[TB] reset while draining");
        loadRamp(16'h0300, 16'h0700);
        applyStimulus(0, 1, 1);
        applyPartial(7);
        @(negedge clock);
        #1;
        compareVal("pre_reset_index", int'(out_index), 5);
        compareVal("pre_reset_valid", int'(out_valid), 1);
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        #1;
        checkResetState();
        sbQ.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        $display("[TB] extreme values after reset");
        for (int b = 0; b < N; b++) begin
            case (b % 3)
                0:       begin frameR[b] = 16'h8000; frameI[b] = 16'h7FFF; end
                1:       begin frameR[b] = 16'h7FFF; frameI[b] = 16'hFFFF; end
                default: begin frameR[b] = 16'hFFFF; frameI[b] = 16'h8000; end
            endcase
        end
        applyStimulus(0, 0, 0);
        goIdle();
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_reorder_buffer.md
# fft_reorder_buffer

Output reorder buffer for the pipelined radix-2² SDF FFT. It consumes the bit-reversed-order sample stream leaving the last butterfly/twiddle stage and re-emits each frame in natural frequency order (X[0], X[1], … X[N-1]). It uses a ping-pong pair of frame banks: one bank fills while the other drains. It sits between the final pipeline stage and the bus-side output FIFO/WISHBONE slave.

## Interface

Parameters:
- data_width, 16: width of each real/imag sample
- log2_n, 6: log2 of FFT length; N = 2^log2_n

Ports:
- clock  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  input sample strobe, same meaning as the pipeline enable; one sample per cycle when high
- frame_start  in  1  qualifies with enable; marks sample 0 of a frame
- in_r  in  data_width  real part, bit-reversed order
- in_i  in  data_width  imaginary part, bit-reversed order
- out_valid  out  1  out_r/out_i/out_index are valid this cycle
- out_r  out  data_width  real part, natural order
- out_i  out  data_width  imaginary part, natural order
- out_index  out  log2_n  frequency bin of the current output
- out_last  out  1  high with bin N-1
- sync_err  out  1  sticky flag: frame_start seen mid-frame

## Operation

Write side:
- wr_cnt (log2_n bits) and wr_bank (1 bit).
- On enable: write {wr_bank, bitrev(wr_cnt)}, then increment wr_cnt.
- enable && frame_start: the sample is written at index 0.
  - If wr_cnt ≠ 0, discard the partial frame: wr_cnt restarts, the bank is not marked full, and sync_err is set.
- enable && frame_start is not required when wr_cnt = 0. The stream is self-framing after the first frame.
- Writing index N-1 sets full[wr_bank] and toggles wr_bank.

Read side FSM:
- IDLE: when full[rd_bank] = 1, go to READ and issue rd_cnt = 0.
- READ: issue one address {rd_bank, rd_cnt} per cycle, with rd_cnt incrementing. At rd_cnt = N-1:
  - clear full[rd_bank] and toggle rd_bank;
  - if full of the new bank is already set, stay in READ with rd_cnt = 0 (back-to-back frames, no gap);
  - otherwise go to IDLE.
- Draining takes exactly N cycles and filling takes at least N cycles, so a bank never refills before it has drained. No overflow path and no backpressure exist.
- A set and a clear of the same full bit in one cycle cannot occur. Set has priority if it ever does.

Arithmetic/widths:
- No arithmetic on the data; it passes through bit-exact.
- bitrev reverses all log2_n bits.
- Counters wrap modulo N.

Reset (asynchronous):
- wr_cnt, rd_cnt, wr_bank, rd_bank and full[1:0] clear to 0.
- FSM goes to IDLE.
- out_valid, out_last, out_r, out_i, out_index and sync_err clear to 0.
- RAM contents are not reset.
- Reset mid-frame drops all buffered data.

## Timing

- Memory read is registered; the output register adds 1 stage.
- The last input sample of a frame is written at edge E. Read address 0 is issued at edge E+1. out_valid/bin 0 appear after edge E+2.
- Latency from last input sample to first output is 2 cycles.
- out_valid stays high for N consecutive cycles per frame. With continuous input it stays high indefinitely.
- out_last is high only with out_index = N-1.
- sync_err rises the cycle after the offending frame_start.

## Structure

- Package fft_reorder_pkg holds:
  - function bitrev(value, width);
  - FSM state encoding (ST_IDLE, ST_READ).
- Sub-module reorder_ram:
  - simple dual-port memory, 2·N × 2·data_width;
  - one write port, one synchronous read port;
  - instantiated once, with bank select as the address MSB.

## Test plan

Run all scenarios with log2_n = 4 (N = 16), data_width = 16.

1. Single frame: feed in_r = bitrev(k), in_i = 100+bitrev(k) for k = 0..15 with frame_start at k = 0.
   - Expect out_r = 0..15 and out_i = 100..115.
   - out_index is 0..15, and out_last is high only at index 15.
   - First out_valid appears 2 cycles after the last input.
2. Continuous stream: 4 back-to-back frames with enable held high.
   - Expect 64 consecutive out_valid cycles with no gap, each frame in natural order.
3. Gapped input: enable high every third cycle for one frame.
   - Expect identical output values.
   - Output burst of 16 contiguous cycles starting 2 cycles after the 16th accepted sample.
4. Mid-frame resync: frame_start at sample 7 of frame 1.
   - Expect sync_err = 1 from the next cycle; the partial frame produces no output.
   - The next full frame outputs correctly.
5. Reset mid-operation: assert reset while bank 0 drains at out_index = 5 and bank 1 is half full.
   - Expect out_valid = 0, all outputs 0 and sync_err = 0 immediately.
   - The first full frame after reset outputs correctly.
6. Bit-exactness: in_r/in_i carry extreme values 0x8000, 0x7FFF, 0xFFFF.
   - These appear unchanged at their natural-order bins.
